// File: rtl/stupidrv_pkg.sv
// Shared types and constants for the stupidrv memory arbiter.
package stupidrv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STRB_WIDTH = 4;

  // Canonical RISC-V NOP (addi x0, x0, 0), presented to the core out of reset
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // Kind of response expected on mem_rdata in the cycle after an acceptance
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_FETCH,
    RESP_LOAD,
    RESP_STORE
  } resp_t;

  // One memory request as driven onto the shared port
  typedef struct packed {
    logic [XLEN-1:0]       addr;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [XLEN-1:0]       wdata;
  } mem_req_t;

  // A data request with no byte strobes is a load, anything else is a store
  function automatic resp_t data_resp(input logic [STRB_WIDTH-1:0] wstrb);
    return (wstrb == '0) ? RESP_LOAD : RESP_STORE;
  endfunction

endpackage

// File: rtl/stupidrv_memarb_cnt.sv
// Free-running wrapping event counter with enable, used for arbiter perf statistics.
module stupidrv_memarb_cnt
  import stupidrv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, wrapping modulo 2^WIDTH
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stupidrv_memarb.sv
// Arbiter sharing one single-port memory between the stupidrv fetch and data ports.
// Data accesses win over fetch and stall the core until accepted; fetched instruction
// and load data are held so the core sees stable values across stalls.
// Optional perf counters are built when STUPIDRV_MEMARB_PERF_EN is defined.
module stupidrv_memarb
  import stupidrv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall_in,
  output logic                  stall,
  input  logic [XLEN-1:0]       imem_addr,
  output logic [XLEN-1:0]       imem_data,
  input  logic                  dmem_valid,
  input  logic [XLEN-1:0]       dmem_addr,
  input  logic [STRB_WIDTH-1:0] dmem_wstrb,
  input  logic [XLEN-1:0]       dmem_wdata,
  output logic [XLEN-1:0]       dmem_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
`ifdef STUPIDRV_MEMARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  perf_fetch,
  output logic [CNT_WIDTH-1:0]  perf_data,
  output logic [CNT_WIDTH-1:0]  perf_stall
`endif
);

  resp_t           resp;
  logic            data_done;
  logic [XLEN-1:0] insn_q;
  logic [XLEN-1:0] dmem_rdata_q;

  logic            data_sel;
  logic            accept;
  mem_req_t        req;

  // Per-cycle request select: external stall, then pending data, then fetch
  always_comb begin
    mem_valid = 1'b0;
    stall     = 1'b0;
    data_sel  = 1'b0;
    req       = '0;
    if (!reset) begin
      if (stall_in) begin
        stall = 1'b1;
      end else if (dmem_valid && !data_done) begin
        data_sel  = 1'b1;
        mem_valid = 1'b1;
        stall     = 1'b1;
        req       = '{addr: dmem_addr, wstrb: dmem_wstrb, wdata: dmem_wdata};
      end else begin
        mem_valid = 1'b1;
        stall     = !mem_ready;
        req.addr  = imem_addr;
      end
    end
  end

  assign accept    = mem_valid && mem_ready;

  assign mem_addr  = req.addr[ADDR_WIDTH-1:0];
  assign mem_wstrb = req.wstrb;
  assign mem_wdata = req.wdata;

  // A fetch response goes straight to the core; otherwise replay the held instruction
  assign imem_data  = (resp == RESP_FETCH) ? mem_rdata : insn_q;
  assign dmem_rdata = dmem_rdata_q;

  // Response tracking, data-done flag and captured read data
  always_ff @(posedge clock) begin
    if (reset) begin
      resp         <= RESP_NONE;
      data_done    <= 1'b0;
      insn_q       <= NOP;
      dmem_rdata_q <= '0;
    end else begin
      case (resp)
        RESP_FETCH: insn_q       <= mem_rdata;
        RESP_LOAD:  dmem_rdata_q <= mem_rdata;
        default:    ;
      endcase

      if (!accept) begin
        resp <= RESP_NONE;
      end else if (data_sel) begin
        resp <= data_resp(req.wstrb);
      end else begin
        resp <= RESP_FETCH;
      end

      if (accept && data_sel) begin
        data_done <= 1'b1;
      end else if (!stall) begin
        data_done <= 1'b0;
      end
    end
  end

`ifdef STUPIDRV_MEMARB_PERF_EN
  // Accepted fetches
  stupidrv_memarb_cnt #(.WIDTH(CNT_WIDTH)) u_cnt_fetch (
    .clock (clock),
    .reset (reset),
    .en    (accept && !data_sel),
    .count (perf_fetch)
  );

  // Accepted data requests
  stupidrv_memarb_cnt #(.WIDTH(CNT_WIDTH)) u_cnt_data (
    .clock (clock),
    .reset (reset),
    .en    (accept && data_sel),
    .count (perf_data)
  );

  // Cycles the core is stalled
  stupidrv_memarb_cnt #(.WIDTH(CNT_WIDTH)) u_cnt_stall (
    .clock (clock),
    .reset (reset),
    .en    (stall),
    .count (perf_stall)
  );
`else
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH'(0);
`endif

endmodule

// File: tb/tb_stupidrv_memarb.sv
// Scoreboard bench for stupidrv_memarb: a core-like driver issues steps (fetch plus
// optional load/store) and pushes expected memory requests; a monitor acting as the
// memory checks requests, stall, instruction and load data against a golden memory.
module tb_stupidrv_memarb;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CW  = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        stall;
  logic [31:0] imem_addr = 32'h0;
  logic [31:0] imem_data;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef STUPIDRV_MEMARB_PERF_EN
  logic [CW-1:0] perf_fetch, perf_data, perf_stall;
`endif

  stupidrv_memarb #(.ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .stall_in   (stall_in),
    .stall      (stall),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wstrb (dmem_wstrb),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef STUPIDRV_MEMARB_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_data  (perf_data),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  // kind: 0 fetch, 1 load, 2 store
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          kind;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] gm[logic [31:0]];
  logic [31:0] sm[logic [31:0]];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] gm_read(input logic [31:0] a);
    return gm.exists(a) ? gm[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] sm_read(input logic [31:0] a);
    return sm.exists(a) ? sm[a] : seed_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor / memory model state
  logic        ins_pend = 1'b0;
  logic [31:0] ins_val = 32'h0;
  int          ld_stage = 0;
  logic [31:0] ld_val = 32'h0;
  logic [31:0] exp_insn = NOP;
  logic [31:0] exp_load = 32'h0;
  logic [31:0] next_rdata = 32'h0;
  logic [31:0] rd;
  bit          step_done = 1'b0;
  bit          exp_stall;
  exp_t        f;
  logic [CW-1:0] pf = '0, pd = '0, ps = '0;

  // Memory returns read data one cycle after acceptance, junk otherwise
  always @(posedge clock) begin
    #1;
    mem_rdata = next_rdata;
  end

  always @(negedge clock) begin
    next_rdata = $urandom;
    if (reset) begin
      chk("reset_mem_valid", 32'(mem_valid), 32'h0);
      chk("reset_stall", 32'(stall), 32'h0);
      expq.delete();
      ins_pend  = 1'b0;
      ld_stage  = 0;
      exp_insn  = NOP;
      exp_load  = 32'h0;
      step_done = 1'b0;
      pf = '0; pd = '0; ps = '0;
    end else begin
`ifdef STUPIDRV_MEMARB_PERF_EN
      chk("perf_fetch", 32'(perf_fetch), 32'(pf));
      chk("perf_data", 32'(perf_data), 32'(pd));
      chk("perf_stall", 32'(perf_stall), 32'(ps));
`endif
      if (ins_pend) begin
        exp_insn = ins_val;
        ins_pend = 1'b0;
      end
      if (ld_stage == 2) begin
        exp_load = ld_val;
        ld_stage = 0;
      end else if (ld_stage == 1) begin
        ld_stage = 2;
      end
      chk("imem_data", imem_data, exp_insn);
      chk("dmem_rdata", dmem_rdata, exp_load);

      if (stall_in) chk("stall_in_blocks_req", 32'(mem_valid), 32'h0);
      else if (expq.size() != 0) chk("req_issued", 32'(mem_valid), 32'h1);

      if (mem_valid && expq.size() != 0) begin
        f = expq[0];
        chk("req_addr", mem_addr, f.addr);
        chk("req_wstrb", 32'(mem_wstrb), 32'(f.wstrb));
        if (f.kind != 0) chk("req_wdata", mem_wdata, f.wdata);
        if (mem_ready) begin
          void'(expq.pop_front());
          rd = sm_read(mem_addr);
          if (mem_wstrb != 4'h0) sm[mem_addr] = merge(rd, mem_wdata, mem_wstrb);
          next_rdata = rd;
          if (f.kind == 0) begin
            ins_pend = 1'b1;
            ins_val  = f.data;
            pf++;
          end else begin
            pd++;
            if (f.kind == 1) begin
              ld_stage = 1;
              ld_val   = f.data;
            end
          end
        end
      end else if (mem_valid) begin
        chk("unexpected_req", 32'(mem_valid), 32'h0);
      end

      // Core is released exactly when everything its step needs has been accepted
      exp_stall = stall_in || (expq.size() != 0);
      chk("stall", 32'(stall), 32'(exp_stall));
      if (exp_stall) ps++;
      step_done = !stall;
    end
  end

  task automatic push_step(input logic [31:0] ia, input bit dv, input logic [31:0] da,
                           input logic [3:0] ws, input logic [31:0] wd);
    exp_t e;
    imem_addr  = ia;
    dmem_valid = dv;
    dmem_addr  = da;
    dmem_wstrb = ws;
    dmem_wdata = wd;
    if (dv) begin
      e.addr = da; e.wstrb = ws; e.wdata = wd;
      if (ws == 4'h0) begin
        e.kind = 1;
        e.data = gm_read(da);
      end else begin
        e.kind = 2;
        e.data = 32'h0;
        gm[da] = merge(gm_read(da), wd, ws);
      end
      expq.push_back(e);
    end
    e.addr = ia; e.wstrb = 4'h0; e.wdata = 32'h0; e.kind = 0; e.data = gm_read(ia);
    expq.push_back(e);
  endtask

  // Caller sits just after a posedge; returns just after the posedge ending the step
  task automatic run_step(input logic [31:0] ia, input bit dv, input logic [31:0] da,
                          input logic [3:0] ws, input logic [31:0] wd,
                          input int rdy_pct, input int sin_pct,
                          input int rdy_hold, input int sin_hold);
    int n;
    push_step(ia, dv, da, ws, wd);
    n = 0;
    forever begin
      mem_ready = (n < rdy_hold) ? 1'b0 : ($urandom_range(99) < 32'(rdy_pct));
      stall_in  = (n < sin_hold) ? 1'b1 : ($urandom_range(99) < 32'(sin_pct));
      @(posedge clock); #1;
      if (step_done) break;
      n++;
      if (n > 200) begin
        n_checks++;
        $display("FAIL step_timeout: step at imem_addr %h never released, expected release within 200 cycles", ia);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  endtask

  logic [31:0] ia, da, wd;
  logic [3:0]  ws;
  int          k;

  initial begin
    gm[32'h100]  = 32'h0050_0093; sm[32'h100]  = 32'h0050_0093;
    gm[32'h2000] = 32'hDEAD_BEEF; sm[32'h2000] = 32'hDEAD_BEEF;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed: fetch, load, store, fetch under backpressure, load behind stall_in
    run_step(32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 100, 0, 0, 0);
    run_step(32'h104, 1'b1, 32'h2000, 4'h0, 32'h0, 100, 0, 0, 0);
    run_step(32'h108, 1'b1, 32'h2004, 4'b0011, 32'h0000_1234, 100, 0, 0, 0);
    run_step(32'h104, 1'b0, 32'h0, 4'h0, 32'h0, 100, 0, 3, 0);
    run_step(32'h10C, 1'b1, 32'h2004, 4'h0, 32'h5555_AAAA, 100, 0, 0, 3);

    // Reset arrives in the response cycle of an accepted load
    mem_ready = 1'b1;
    stall_in  = 1'b0;
    push_step(32'h110, 1'b1, 32'h2000, 4'h0, 32'h0);
    @(posedge clock); #1;
    reset      = 1'b1;
    dmem_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    run_step(32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 100, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      ia = 32'h100 + ($urandom_range(15) << 2);
      da = 32'h2000 + ($urandom_range(7) << 2);
      wd = $urandom;
      ws = 4'($urandom_range(15, 1));
      k  = int'($urandom_range(3));
      case (k)
        2:       run_step(ia, 1'b1, da, 4'h0, wd, 70, 15, 0, 0);
        3:       run_step(ia, 1'b1, da, ws, wd, 70, 15, 0, 0);
        default: run_step(ia, 1'b0, da, 4'h0, wd, 70, 15, 0, 0);
      endcase
    end

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
